// File: rtl/sm_bsr_chain.sv
// Parametrised single-clock boundary-scan data register for the SchoolMIPS debug path.
// Optional 1-bit bypass path is built only when SM_BSR_BYPASS_EN is defined.
module sm_bsr_chain #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_data_in,
  output logic [WIDTH-1:0] p_data_out,
  input  logic             s_data_in,
  output logic             s_data_out,
  input  logic             mode,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             bypass,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             shift_full,
  output logic             upd_done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] shReg_q,   shReg_d;
  logic [WIDTH-1:0] updReg_q,  updReg_d;
  logic [CNT_W-1:0] bitCnt_q,  bitCnt_d;
  logic             updDone_q, updDone_d;
  logic             bypassActive;

`ifdef SM_BSR_BYPASS_EN
  logic bypReg_q, bypReg_d;

  assign bypassActive = bypass;

  always_comb begin
    bypReg_d = bypReg_q;
    if (bypassActive) begin
      if (capture_dr) begin
        bypReg_d = 1'b0;
      end else if (shift_dr) begin
        bypReg_d = s_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bypReg_q <= 1'b0;
    end else begin
      bypReg_q <= bypReg_d;
    end
  end

  assign s_data_out = bypassActive ? bypReg_q : shReg_q[0];
`else
  // Without the bypass feature the select input is tied off to a constant zero.
  assign bypassActive = 1'b0 & bypass;
  assign s_data_out   = shReg_q[0];
`endif

  // Update copies the pre-edge shift contents, so a same-cycle shift never leaks in.
  always_comb begin
    shReg_d   = shReg_q;
    updReg_d  = updReg_q;
    bitCnt_d  = bitCnt_q;
    updDone_d = 1'b0;
    if (!bypassActive) begin
      if (capture_dr) begin
        shReg_d  = p_data_in;
        bitCnt_d = '0;
      end else if (shift_dr) begin
        shReg_d = {s_data_in, shReg_q[WIDTH-1:1]};
        if (bitCnt_q != CNT_FULL) begin
          bitCnt_d = bitCnt_q + CNT_ONE;
        end
      end
      if (update_dr) begin
        updReg_d  = shReg_q;
        updDone_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shReg_q   <= '0;
      updReg_q  <= RESET_VALUE;
      bitCnt_q  <= '0;
      updDone_q <= 1'b0;
    end else begin
      shReg_q   <= shReg_d;
      updReg_q  <= updReg_d;
      bitCnt_q  <= bitCnt_d;
      updDone_q <= updDone_d;
    end
  end

  assign p_data_out = mode ? updReg_q : p_data_in;
  assign bit_cnt    = bitCnt_q;
  assign shift_full = (bitCnt_q == CNT_FULL);
  assign upd_done   = updDone_q;

endmodule

// File: tb/tb_sm_bsr_chain.sv
// Self-checking bench for sm_bsr_chain: directed scenarios plus random strobes vs a queue-based model.
module tb_sm_bsr_chain;

   localparam int          W  = 32;
   localparam int          CW = $clog2(W + 1);
   localparam logic [31:0] RV = 32'hA5A5_0000;

   logic          clock;
   logic          rst;
   logic [W-1:0]  pIn;
   logic [W-1:0]  pOut;
   logic          sIn;
   logic          sOut;
   logic          mode;
   logic          cap;
   logic          sh;
   logic          upd;
   logic          byp;
   logic [CW-1:0] bitCnt;
   logic          full;
   logic          updDone;

   int errors = 0;
   int checks = 0;

   // Reference model: the chain is a queue of bits, front = next bit to leave on TDO.
   bit          mq[$];
   int          mCnt;
   logic [31:0] mUpd;
   bit          mDone;
   bit          mByp;
`ifdef SM_BSR_BYPASS_EN
   localparam bit BYP_EN = 1'b1;
`else
   localparam bit BYP_EN = 1'b0;
`endif

   sm_bsr_chain #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .clk(clock), .rst(rst), .p_data_in(pIn), .p_data_out(pOut),
      .s_data_in(sIn), .s_data_out(sOut), .mode(mode),
      .capture_dr(cap), .shift_dr(sh), .update_dr(upd), .bypass(byp),
      .bit_cnt(bitCnt), .shift_full(full), .upd_done(updDone)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] packChain();
      logic [31:0] w;
      for (int i = 0; i < W; i++) w[i] = mq[i];
      return w;
   endfunction

   // Advances the model by one clock edge with the inputs currently applied.
   task automatic modelEdge();
      logic [31:0] oldWord;
      bit bypAct;
      bypAct = BYP_EN && byp;
      if (rst) begin
         mq.delete();
         for (int i = 0; i < W; i++) mq.push_back(1'b0);
         mCnt = 0; mUpd = RV; mDone = 1'b0; mByp = 1'b0;
      end else begin
         oldWord = packChain();
         mDone = upd && !bypAct;
         if (bypAct) begin
            if (cap) mByp = 1'b0;
            else if (sh) mByp = sIn;
         end else begin
            if (cap) begin
               mq.delete();
               for (int i = 0; i < W; i++) mq.push_back(pIn[i]);
               mCnt = 0;
            end else if (sh) begin
               void'(mq.pop_front());
               mq.push_back(sIn);
               mCnt = (mCnt + 1 > W) ? W : mCnt + 1;
            end
            if (upd) mUpd = oldWord;
         end
      end
   endtask

   task automatic checkAll(input string tag);
      bit bypAct;
      bypAct = BYP_EN && byp;
      checkOutput({tag, ".pOut"}, pOut, mode ? mUpd : pIn);
      checkOutput({tag, ".sOut"}, {31'd0, sOut}, {31'd0, bypAct ? mByp : mq[0]});
      checkOutput({tag, ".bitCnt"}, 32'(bitCnt), 32'(mCnt));
      checkOutput({tag, ".full"}, {31'd0, full}, {31'd0, mCnt == W});
      checkOutput({tag, ".updDone"}, {31'd0, updDone}, {31'd0, mDone});
   endtask

   // Drive one cycle of inputs, clock it, then compare everything against the model.
   task automatic applyStimulus(input string tag, input logic r, input logic c, input logic s,
                                input logic u, input logic m, input logic b,
                                input logic [31:0] pi, input logic si);
      rst = r; cap = c; sh = s; upd = u; mode = m; byp = b; pIn = pi; sIn = si;
      @(posedge clock);
      modelEdge();
      #1;
      checkAll(tag);
   endtask

   initial begin
      logic [31:0] word;
      rst = 1'b1; cap = 0; sh = 0; upd = 0; mode = 1; byp = 0; pIn = '0; sIn = 0;

      // Reset state with mode=1
      applyStimulus("reset", 1, 0, 0, 0, 1, 0, 32'h0, 0);
      checkOutput("reset.pOutConst", pOut, 32'hA5A5_0000);

      // Capture 0x12345678 then shift 33 zeros; TDO shows the word LSB first
      word = 32'h1234_5678;
      applyStimulus("cap", 0, 1, 0, 0, 0, 0, word, 0);
      checkOutput("cap.bit0", {31'd0, sOut}, {31'd0, word[0]});
      for (int i = 1; i <= 33; i++) begin
         applyStimulus("shift", 0, 0, 1, 0, 0, 0, 32'h0, 0);
         checkOutput("shift.bitSeq", {31'd0, sOut}, (i < 32) ? {31'd0, word[i]} : 32'd0);
      end
      checkOutput("shift.cntSat", 32'(bitCnt), 32'd32);
      checkOutput("shift.fullHold", {31'd0, full}, 32'd1);

      // Shift DEADBEEF in LSB first, update, observe in test mode
      word = 32'hDEAD_BEEF;
      for (int i = 0; i < 32; i++) applyStimulus("loadWord", 0, 0, 1, 0, 1, 0, 32'h0, word[i]);
      applyStimulus("update", 0, 0, 0, 1, 1, 0, 32'h0, 0);
      checkOutput("update.pOut", pOut, 32'hDEAD_BEEF);
      checkOutput("update.donePulse", {31'd0, updDone}, 32'd1);
      applyStimulus("afterUpd", 0, 0, 0, 0, 1, 0, 32'h0, 0);
      checkOutput("afterUpd.doneLow", {31'd0, updDone}, 32'd0);
      applyStimulus("funcMode", 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 0);
      checkOutput("funcMode.pOut", pOut, 32'h0BAD_F00D);

      // Simultaneous shift+update: update takes pre-shift contents
      applyStimulus("cap3", 0, 1, 0, 0, 1, 0, 32'h0000_0003, 0);
      applyStimulus("shUpd", 0, 0, 1, 1, 1, 0, 32'h0, 1);
      checkOutput("shUpd.updReg", pOut, 32'h0000_0003);
      checkOutput("shUpd.sOut", {31'd0, sOut}, 32'd1);

      // Capture beats shift
      applyStimulus("capShift", 0, 1, 1, 0, 1, 0, 32'hFFFF_0000, 1);
      checkOutput("capShift.cnt", 32'(bitCnt), 32'd0);

      // Reset mid-shift at bit 10
      for (int i = 0; i < 10; i++) applyStimulus("preRst", 0, 0, 1, 0, 1, 0, 32'h0, 1);
      applyStimulus("midRst", 1, 0, 1, 1, 1, 0, 32'h0, 1);
      checkOutput("midRst.pOut", pOut, 32'hA5A5_0000);
      checkOutput("midRst.cnt", 32'(bitCnt), 32'd0);

`ifdef SM_BSR_BYPASS_EN
      // Bypass: one-cycle lag and update ignored
      applyStimulus("bypCap", 0, 1, 0, 0, 1, 1, 32'h0, 0);
      applyStimulus("byp1", 0, 0, 1, 0, 1, 1, 32'h0, 1);
      checkOutput("byp1.lag", {31'd0, sOut}, 32'd1);
      applyStimulus("byp0", 0, 0, 1, 0, 1, 1, 32'h0, 0);
      checkOutput("byp0.lag", {31'd0, sOut}, 32'd0);
      applyStimulus("byp1b", 0, 0, 1, 1, 1, 1, 32'h0, 1);
      checkOutput("byp1b.lag", {31'd0, sOut}, 32'd1);
      checkOutput("byp.updIgnored", pOut, 32'hA5A5_0000);
`endif

      // Random strobes against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand",
                       $urandom_range(0, 40) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                       $urandom, $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sm_bsr_chain.md
# sm_bsr_chain

Single-clock, parametrised boundary-scan data register for the SchoolMIPS debug path, replacing the fixed-width, multi-clock scan cells on the CPU register-address/data boundary. It captures a WIDTH-bit parallel core-side word, shifts it serially between TDI-side and TDO-side pins, and drives a held update word onto the core side when in test mode. All scan strobes are clock enables sampled on `clk`. Over the older cells it adds:
- explicit capture;
- a shift bit counter with a full flag;
- an update-done pulse;
- an optional 1-bit bypass path.

## Interface

Parameters:
- `WIDTH`, 32: scan/parallel data width, ≥ 2.
- `RESET_VALUE`, 0: reset contents of the update register, WIDTH bits.
- `CNT_W`, `$clog2(WIDTH+1)`: bit-counter width; derived, do not override.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `p_data_in` in WIDTH: functional word from the core side.
- `p_data_out` out WIDTH: word to the consumer side.
- `s_data_in` in 1: serial input (TDI side).
- `s_data_out` out 1: serial output (TDO side).
- `mode` in 1: 0 = functional, 1 = test (drive update register).
- `capture_dr` in 1: capture strobe, one-cycle enable.
- `shift_dr` in 1: shift strobe, one bit per cycle while high.
- `update_dr` in 1: update strobe, one-cycle enable.
- `bypass` in 1: select 1-bit bypass path. Present always; ignored unless `SM_BSR_BYPASS_EN`.
- `bit_cnt` out CNT_W: bits shifted since last capture, saturating at WIDTH.
- `shift_full` out 1: `bit_cnt == WIDTH`.
- `upd_done` out 1: one-cycle pulse after an update took effect.

## Operation

Internal registers:
- `sh_reg[WIDTH-1:0]`
- `upd_reg[WIDTH-1:0]`
- `bit_cnt`
- `upd_done`
- `byp_reg` (with macro only)

Combinational outputs:
- `p_data_out = mode ? upd_reg : p_data_in`.
- `s_data_out = sh_reg[0]`, or `byp_reg` when bypass is active.

Strobe priority per edge: `capture_dr` > `shift_dr`. `update_dr` is independent of both.

- Capture: `sh_reg <= p_data_in`; `bit_cnt <= 0`.
- Shift (no capture): `sh_reg <= {s_data_in, sh_reg[WIDTH-1:1]}`, LSB exits first. `bit_cnt <= min(bit_cnt+1, WIDTH)`.
- Update: `upd_reg <= sh_reg` value before this edge, so a simultaneous shift does not leak into the update. `upd_done <= 1` on the next edge only; otherwise `upd_done <= 0`.
- Shifting beyond WIDTH bits keeps rotating data through: `bit_cnt` stays at WIDTH, `shift_full` stays 1, no error.
- `mode` only steers the output mux. It never gates the strobes, so capture/shift/update work in functional mode (sample-only use).
- No state machine. The external TAP sequences the strobes; the block obeys each strobe every cycle.

## Timing

- Reset, on the first edge with `rst`=1:
  - `sh_reg` = 0, `upd_reg` = RESET_VALUE, `bit_cnt` = 0, `upd_done` = 0, `byp_reg` = 0.
  - Hence `s_data_out` = 0, and `p_data_out` = RESET_VALUE if `mode`=1.
- `rst` overrides all strobes in that cycle. Reset mid-shift discards the partial word.
- Capture latency: 1 edge. The `p_data_in` value present at the edge is stored, and `s_data_out` shows bit 0 immediately after.
- Shift: the new `s_data_out` is valid after each shift edge. A full word needs WIDTH shift cycles.
- Update: `p_data_out` changes (if `mode`=1) right after the update edge. `upd_done` is high during the following cycle.
- `mode` toggles take effect combinationally, with no latency.

## Configuration

- `SM_BSR_BYPASS_EN` defined, and `bypass`=1:
  - Capture: `byp_reg <= 0`.
  - Shift: `byp_reg <= s_data_in`.
  - `s_data_out = byp_reg`.
  - `sh_reg`, `upd_reg` and `bit_cnt` hold; update is ignored and `upd_done` stays 0.
  - Chain length is 1 bit.
- `SM_BSR_BYPASS_EN` undefined: `byp_reg` is not built, `bypass` is ignored, and behaviour is as if `bypass`=0.

## Test plan

- Reset with `mode`=1, RESET_VALUE=32'hA5A5_0000 → `p_data_out`=32'hA5A5_0000, `s_data_out`=0, `bit_cnt`=0, `upd_done`=0.
- `p_data_in`=32'h1234_5678, capture, then 32 shifts with `s_data_in`=0 → `s_data_out` emits 0,0,0,1,1,1,1,0,… (LSB first); `bit_cnt` reaches 32; `shift_full`=1 and holds after a 33rd shift.
- Shift in 32'hDEAD_BEEF LSB first, update, `mode`=1 → `p_data_out`=32'hDEAD_BEEF one edge later; `upd_done` pulses exactly 1 cycle. With `mode`=0, `p_data_out` follows `p_data_in`.
- Simultaneous `shift_dr`+`update_dr` with `sh_reg`=32'h0000_0003 and `s_data_in`=1 → `upd_reg`=32'h0000_0003; `sh_reg`=32'h8000_0001.
- Simultaneous `capture_dr`+`shift_dr` → capture wins, `bit_cnt`=0. `rst` asserted mid-shift (bit 10) → all state returns to reset values on that edge.
- With `SM_BSR_BYPASS_EN` and `bypass`=1, shift 1,0,1 → `s_data_out` lags `s_data_in` by exactly 1 cycle; `upd_reg` is unchanged after an update strobe.
